// File: rtl/pkt_unpacker.sv
// Splits a header-prefixed word stream from a FWFT FIFO into framed payload
// packets carrying sop/eop markers, a destination tag and a delivered-packet count.
module pkt_unpacker #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int DEST_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [DEST_WIDTH-1:0] out_dest,
  output logic [15:0]           pkt_cnt,
  output logic                  err_zero_len
);

  typedef enum logic {
    IDLE,
    PAYLOAD
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [LEN_WIDTH-1:0]  rem;
  logic                  first;
  logic [DEST_WIDTH-1:0] dest_pend;
  logic [LEN_WIDTH-1:0]  hdr_len;
  logic [DEST_WIDTH-1:0] hdr_dest;
  logic                  hdr_pop;
  logic                  load;
  logic                  last_word;

  assign hdr_len   = fifo_dout[LEN_WIDTH-1:0];
  assign hdr_dest  = fifo_dout[LEN_WIDTH+DEST_WIDTH-1:LEN_WIDTH];
  assign last_word = (rem == LEN_WIDTH'(1));

  // The header pop ignores the output stage, so a new header can be taken
  // while the previous packet's last word is still waiting on out_ready.
  always_comb begin
    state_next = state;
    hdr_pop    = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        hdr_pop = rst_n && !fifo_empty;
        if (hdr_pop && (hdr_len != '0)) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        load = !fifo_empty && (!out_valid || out_ready);
        if (load && last_word) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    fifo_rd_en = hdr_pop || load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rem          <= '0;
      first        <= 1'b1;
      dest_pend    <= '0;
      err_zero_len <= 1'b0;
    end else begin
      state        <= state_next;
      err_zero_len <= hdr_pop && (hdr_len == '0);
      if (hdr_pop && (hdr_len != '0)) begin
        rem       <= hdr_len;
        dest_pend <= hdr_dest;
        first     <= 1'b1;
      end
      if (load) begin
        rem   <= rem - LEN_WIDTH'(1);
        first <= 1'b0;
      end
    end
  end

  // out_dest is only refreshed from the pending copy when a payload word loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_dest  <= '0;
    end else if (load) begin
      out_data  <= fifo_dout;
      out_valid <= 1'b1;
      out_sop   <= first;
      out_eop   <= last_word;
      out_dest  <= dest_pend;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else if (out_valid && out_ready && out_eop) begin
      pkt_cnt <= pkt_cnt + 16'd1;
    end
  end

endmodule
